// File: rtl/debug_pkg.sv
// Shared types and default timing constants for the debug-harness step controller.
package debug_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_RUN   = 2'b01,
        MODE_BREAK = 2'b10
    } mode_t;

    localparam int DEBOUNCE_CYC_DEF = 500000;
    localparam int RUN_DIV_DEF      = 5000000;
    localparam int PC_W_DEF         = 32;

endpackage

// File: rtl/step_ctrl_if.sv
// Board-input / core-side bundle of the step controller; slave is the controller itself.
interface step_ctrl_if
    import debug_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
);

    logic            key_step_n;
    logic            sw_run;
    logic            bp_en;
    logic [PC_W-1:0] bp_addr;
    logic [PC_W-1:0] pc_in;
    logic            cpu_ce;
    logic [31:0]     step_count;
    mode_t           mode;
    logic            key_level;

    modport master (
        output key_step_n, sw_run, bp_en, bp_addr, pc_in,
        input  cpu_ce, step_count, mode, key_level
    );

    modport slave (
        input  key_step_n, sw_run, bp_en, bp_addr, pc_in,
        output cpu_ce, step_count, mode, key_level
    );

endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stability filter; rise is a one-cycle strobe on a filtered 0->1.
module key_debounce
    import debug_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int               CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            rise   <= 1'b0;
            // any cycle of agreement restarts the stability window
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= ~level;
                rise  <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/step_ctrl.sv
// Turns the debounced step key and run switch into single-cycle clock-enables for the core.
//
//   state      | meaning
//   MODE_IDLE  | core halted; each key press issues one cpu_ce
//   MODE_RUN   | cpu_ce every RUN_DIV cycles; key ignored; breakpoint checked at terminal count
//   MODE_BREAK | halted on breakpoint; key press steps past it
module step_ctrl
    import debug_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int RUN_DIV      = RUN_DIV_DEF
) (
    input logic        CLOCK_50,
    input logic        reset,
    step_ctrl_if.slave bus
);

    localparam int               DIV_W    = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic             key_lvl;
    logic             key_rise;
    logic             run_lvl;
    logic             run_rise_unused;
    logic             bp_hit;
    mode_t            mode_q;
    mode_t            mode_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             ce_q;
    logic             ce_d;
    logic [31:0]      step_cnt_q;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .raw      (~bus.key_step_n),
        .level    (key_lvl),
        .rise     (key_rise)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_run (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .raw      (bus.sw_run),
        .level    (run_lvl),
        .rise     (run_rise_unused)
    );

    assign bp_hit = bus.bp_en && (bus.pc_in == bus.bp_addr);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            mode_q     <= MODE_IDLE;
            div_q      <= '0;
            ce_q       <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            mode_q     <= mode_d;
            div_q      <= div_d;
            ce_q       <= ce_d;
            step_cnt_q <= step_cnt_q + 32'(ce_d);
        end
    end

    always_comb begin
        mode_d = mode_q;
        div_d  = div_q;
        ce_d   = 1'b0;
        case (mode_q)
            MODE_IDLE: begin
                ce_d = key_rise;
                if (run_lvl) begin
                    mode_d = MODE_RUN;
                    div_d  = '0;
                end
            end
            MODE_RUN: begin
                // dropping the run switch beats a coincident terminal count
                if (!run_lvl) begin
                    mode_d = MODE_IDLE;
                    div_d  = '0;
                end else if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bp_hit) mode_d = MODE_BREAK;
                    else        ce_d   = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            MODE_BREAK: begin
                if (key_rise) begin
                    ce_d   = 1'b1;
                    div_d  = '0;
                    mode_d = run_lvl ? MODE_RUN : MODE_IDLE;
                end else if (!run_lvl) begin
                    mode_d = MODE_IDLE;
                end
            end
            default: begin
                mode_d = MODE_IDLE;
                div_d  = '0;
            end
        endcase
    end

    assign bus.cpu_ce     = ce_q;
    assign bus.step_count = step_cnt_q;
    assign bus.mode       = mode_q;
    assign bus.key_level  = key_lvl;

endmodule
